// File: rtl/fetch_engine.sv
// Line-fetch responder for the cache. It accepts one command at a time from
// the read controller. A refill streams a line from external memory into the
// cache data memory. A writeback-and-refill first copies the victim line out
// to external memory, then refills. Each word passes through a
// request / wait-for-data / write sequence, so at most one external
// transaction and at most one data-memory access are outstanding at once.
module fetch_engine #(
  parameter int addr_width = 32,
  parameter int list_depth = 4,
  parameter int data_width = 32,
  parameter int list_width = 32
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            fetch_req,
  input  logic [1:0]                                      fetch_cmd,
  input  logic [$clog2(list_depth)-1:0]                   fetch_tag,
  input  logic [addr_width-1:0]                           fetch_addr,
  input  logic [addr_width-1:0]                           fetch_wb_addr,
  output logic                                            fetch_gnt,
  output logic                                            fetch_done,
  output logic [$clog2(list_depth)+$clog2(list_width)-1:0] mem_waddr,
  output logic                                            mem_wen,
  output logic [data_width-1:0]                           mem_wdata,
  input  logic                                            mem_wready,
  output logic [$clog2(list_depth)+$clog2(list_width)-1:0] mem_raddr,
  output logic                                            mem_ren,
  input  logic                                            mem_rready,
  input  logic [data_width-1:0]                           mem_rdata,
  input  logic                                            mem_rdata_valid,
  output logic                                            ext_req,
  output logic                                            ext_we,
  output logic [addr_width-1:0]                           ext_addr,
  output logic [data_width-1:0]                           ext_wdata,
  input  logic                                            ext_gnt,
  input  logic [data_width-1:0]                           ext_rdata,
  input  logic                                            ext_rdata_valid
);

  localparam int TW = $clog2(list_depth);
  localparam int CW = $clog2(list_width);
  localparam int BW = addr_width - CW;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_RD   = 3'd1,
    WB_WAIT = 3'd2,
    WB_WR   = 3'd3,
    RF_REQ  = 3'd4,
    RF_WAIT = 3'd5,
    RF_WR   = 3'd6,
    DONE    = 3'd7
  } state_t;

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic [TW-1:0]         tag_q;
  logic [BW-1:0]         rf_base_q;
  logic [BW-1:0]         wb_base_q;
  logic [data_width-1:0] wb_data_q;
  logic [data_width-1:0] rf_data_q;

  logic [CW-1:0]         cnt_d;
  logic                  line_last;
  logic                  run;

  // The word offsets of the command addresses are meaningless: a line is
  // always transferred from word 0 upwards.
  logic                  unused_low_bits;
  assign unused_low_bits = ^{fetch_addr[CW-1:0], fetch_wb_addr[CW-1:0]};

  assign cnt_d     = cnt_q + CW'(1);
  assign line_last = (cnt_q == CW'(list_width - 1));
  assign run       = !rst;

  // Command sequencer: one word per request/wait/write round trip.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tag_q     <= '0;
      rf_base_q <= '0;
      wb_base_q <= '0;
      wb_data_q <= '0;
      rf_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fetch_req) begin
            tag_q     <= fetch_tag;
            rf_base_q <= fetch_addr[addr_width-1:CW];
            wb_base_q <= fetch_wb_addr[addr_width-1:CW];
            cnt_q     <= '0;
            case (fetch_cmd)
              2'b01:   state_q <= RF_REQ;
              2'b10:   state_q <= WB_RD;
              default: state_q <= DONE;
            endcase
          end
        end
        WB_RD: begin
          if (mem_rready) state_q <= WB_WAIT;
        end
        WB_WAIT: begin
          if (mem_rdata_valid) begin
            wb_data_q <= mem_rdata;
            state_q   <= WB_WR;
          end
        end
        WB_WR: begin
          if (ext_gnt) begin
            // Victim copied out completely: the refill restarts at word 0.
            cnt_q   <= line_last ? '0 : cnt_d;
            state_q <= line_last ? RF_REQ : WB_RD;
          end
        end
        RF_REQ: begin
          if (ext_gnt) state_q <= RF_WAIT;
        end
        RF_WAIT: begin
          if (ext_rdata_valid) begin
            rf_data_q <= ext_rdata;
            state_q   <= RF_WR;
          end
        end
        RF_WR: begin
          if (mem_wready) begin
            if (line_last) begin
              state_q <= DONE;
            end else begin
              cnt_q   <= cnt_d;
              state_q <= RF_REQ;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode the registered state and are forced low while in reset.
  assign fetch_gnt  = run && (state_q == IDLE);
  assign fetch_done = run && (state_q == DONE);

  assign mem_ren    = run && (state_q == WB_RD);
  assign mem_raddr  = run ? {tag_q, cnt_q} : '0;
  assign mem_wen    = run && (state_q == RF_WR);
  assign mem_waddr  = run ? {tag_q, cnt_q} : '0;
  assign mem_wdata  = run ? rf_data_q : '0;

  assign ext_req    = run && ((state_q == WB_WR) || (state_q == RF_REQ));
  assign ext_we     = run && (state_q == WB_WR);
  assign ext_addr   = !run ? '0 :
                      (state_q == WB_WR) ? {wb_base_q, cnt_q} : {rf_base_q, cnt_q};
  assign ext_wdata  = run ? wb_data_q : '0;

endmodule
